// File: rtl/hamming_apb_sequencer.sv
// hamming_apb_sequencer: APB master that shares one Hamming encoder slave
// among NREQ requesters. Each granted request writes the dataword to IN
// (offset 0x0), reads OUT1 (0x4) and OUT2 (0x8), then returns the 40-bit
// codeword {OUT2[7:0], OUT1} to the requester that issued it.
//
// Ports:
//   PCLK, PRESET            clock, asynchronous active-high reset
//   req_valid[NREQ]         per-requester request
//   req_data[16*NREQ]       flattened datawords, requester i at [16i+15:16i]
//   req_ready[NREQ]         one-hot pulse: request accepted, data captured
//   resp_valid[NREQ]        one-hot pulse: result for requester i
//   resp_data[40]           codeword (zero when resp_err)
//   resp_err                slave error or timeout, qualified by resp_valid
//   busy                    high whenever the sequencer is not idle
//   PADDR/PWDATA/PSEL/PENABLE/PWRITE   APB request side
//   PRDATA/PREADY/PSLVERR              APB response side
//
// All outputs are registers. req_ready is seen in the first setup cycle and
// resp_valid in the cycle after RESP, so an unstalled request takes 7 cycles
// from req_ready to resp_valid and the sequencer accepts one request per 8.
module hamming_apb_sequencer #(
    parameter int unsigned NREQ      = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [16*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      resp_valid,
    output logic [39:0]          resp_data,
    output logic                 resp_err,
    output logic                 busy,
    output logic [31:0]          PADDR,
    output logic [31:0]          PWDATA,
    output logic                 PSEL,
    output logic                 PENABLE,
    output logic                 PWRITE,
    input  logic [31:0]          PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR
);

    localparam int unsigned      PTR_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [31:0]      OFS_IN   = 32'h0000_0000;
    localparam logic [31:0]      OFS_OUT1 = 32'h0000_0004;
    localparam logic [31:0]      OFS_OUT2 = 32'h0000_0008;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_SETUP = 3'd1,
        WR_ACC   = 3'd2,
        R1_SETUP = 3'd3,
        R1_ACC   = 3'd4,
        R2_SETUP = 3'd5,
        R2_ACC   = 3'd6,
        RESP     = 3'd7
    } state_t;

    state_t state, state_next;

    logic [PTR_W-1:0] ptr, ptr_next;
    logic [PTR_W-1:0] gnt, gnt_next;
    logic [15:0]      data, data_next;
    logic [31:0]      out1, out1_next;
    logic [7:0]       out2, out2_next;
    logic             err, err_next;
    logic [CNT_W-1:0] wcnt, wcnt_next;

    logic             grant;
    logic [PTR_W-1:0] grant_idx;
    logic [15:0]      grant_data;
    logic [PTR_W:0]   cand_sum;
    logic             in_setup, in_acc, done_ok, done_err, timeout;

    logic [NREQ-1:0]  req_ready_n, resp_valid_n;
    logic [39:0]      resp_data_n;
    logic             resp_err_n, busy_n;
    logic [31:0]      paddr_n, pwdata_n;
    logic             psel_n, penable_n, pwrite_n;

    // Round-robin search upward from ptr+1, wrapping at NREQ.
    always_comb begin
        grant     = 1'b0;
        grant_idx = '0;
        cand_sum  = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand_sum = {1'b0, ptr} + (PTR_W+1)'(i);
            if (cand_sum >= (PTR_W+1)'(NREQ))
                cand_sum = cand_sum - (PTR_W+1)'(NREQ);
            if (!grant && req_valid[cand_sum[PTR_W-1:0]]) begin
                grant     = 1'b1;
                grant_idx = cand_sum[PTR_W-1:0];
            end
        end
    end

    // Dataword of the winning requester.
    always_comb begin
        grant_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_idx == PTR_W'(i))
                grant_data = req_data[16*i +: 16];
        end
    end

    // Access-phase status shared by the three transfers.
    always_comb begin
        in_setup = (state == WR_SETUP) || (state == R1_SETUP) || (state == R2_SETUP);
        in_acc   = (state == WR_ACC) || (state == R1_ACC) || (state == R2_ACC);
        done_ok  = in_acc && PREADY && !PSLVERR;
        done_err = in_acc && PREADY && PSLVERR;
        timeout  = in_acc && !PREADY && (wcnt >= CNT_LAST);
    end

    // State register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (grant) state_next = WR_SETUP;
            WR_SETUP: state_next = WR_ACC;
            R1_SETUP: state_next = R1_ACC;
            R2_SETUP: state_next = R2_ACC;
            WR_ACC: begin
                if (done_ok)                  state_next = R1_SETUP;
                else if (done_err || timeout) state_next = RESP;
            end
            R1_ACC: begin
                if (done_ok)                  state_next = R2_SETUP;
                else if (done_err || timeout) state_next = RESP;
            end
            R2_ACC: begin
                if (done_ok || done_err || timeout) state_next = RESP;
            end
            RESP:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Datapath: grant capture, read capture, error flag and wait counter.
    always_comb begin
        ptr_next  = ptr;
        gnt_next  = gnt;
        data_next = data;
        out1_next = out1;
        out2_next = out2;
        err_next  = err;
        wcnt_next = wcnt;
        if (state == IDLE && grant) begin
            ptr_next  = grant_idx;
            gnt_next  = grant_idx;
            data_next = grant_data;
        end
        if (state == R1_ACC && done_ok) out1_next = PRDATA;
        if (state == R2_ACC && done_ok) out2_next = PRDATA[7:0];
        if (done_err || timeout)        err_next  = 1'b1;
        if (state == RESP)              err_next  = 1'b0;
        if (in_setup)
            wcnt_next = '0;
        else if (in_acc && !PREADY && wcnt != CNT_MAX)
            wcnt_next = wcnt + CNT_W'(1);
    end

    // Output logic: APB signals follow the upcoming state, pulses follow
    // the transitions out of IDLE and RESP.
    always_comb begin
        psel_n    = 1'b0;
        penable_n = 1'b0;
        pwrite_n  = 1'b0;
        paddr_n   = '0;
        pwdata_n  = '0;
        case (state_next)
            WR_SETUP, WR_ACC: begin
                psel_n    = 1'b1;
                penable_n = (state_next == WR_ACC);
                pwrite_n  = 1'b1;
                paddr_n   = BASE_ADDR + OFS_IN;
                pwdata_n  = {16'h0000, data_next};
            end
            R1_SETUP, R1_ACC: begin
                psel_n    = 1'b1;
                penable_n = (state_next == R1_ACC);
                paddr_n   = BASE_ADDR + OFS_OUT1;
            end
            R2_SETUP, R2_ACC: begin
                psel_n    = 1'b1;
                penable_n = (state_next == R2_ACC);
                paddr_n   = BASE_ADDR + OFS_OUT2;
            end
            default: ;
        endcase
        busy_n       = (state_next != IDLE);
        req_ready_n  = '0;
        resp_valid_n = '0;
        resp_data_n  = '0;
        resp_err_n   = 1'b0;
        if (state == IDLE && grant)
            req_ready_n = NREQ'(1) << grant_idx;
        if (state == RESP) begin
            resp_valid_n = NREQ'(1) << gnt;
            resp_err_n   = err;
            resp_data_n  = err ? 40'h0 : {out2, out1};
        end
    end

    // Datapath and output registers.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ptr        <= '0;
            gnt        <= '0;
            data       <= '0;
            out1       <= '0;
            out2       <= '0;
            err        <= 1'b0;
            wcnt       <= '0;
            req_ready  <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            PSEL       <= 1'b0;
            PENABLE    <= 1'b0;
            PWRITE     <= 1'b0;
        end else begin
            ptr        <= ptr_next;
            gnt        <= gnt_next;
            data       <= data_next;
            out1       <= out1_next;
            out2       <= out2_next;
            err        <= err_next;
            wcnt       <= wcnt_next;
            req_ready  <= req_ready_n;
            resp_valid <= resp_valid_n;
            resp_data  <= resp_data_n;
            resp_err   <= resp_err_n;
            busy       <= busy_n;
            PADDR      <= paddr_n;
            PWDATA     <= pwdata_n;
            PSEL       <= psel_n;
            PENABLE    <= penable_n;
            PWRITE     <= pwrite_n;
        end
    end

endmodule

// File: doc/hamming_apb_sequencer.md
Name: hamming_apb_sequencer

Overview:
- APB master that shares one Hamming encoder APB peripheral between NREQ requesters.
- For each granted request it runs three APB transfers:
  - write the 16-bit dataword to the IN register (offset 0x0);
  - read OUT1 (offset 0x4);
  - read OUT2 (offset 0x8).
- It assembles the 40-bit codeword and returns it to the requester that issued the request.
- It sits between on-chip producers (e.g. memory-protection write paths) and the encoder slave on the same PCLK domain.

Parameters:
- NREQ, 2, number of requesters (2..8).
- BASE_ADDR, 32'h0000_0000, encoder slave base address; PADDR = BASE_ADDR + register offset.
- TIMEOUT, 16, maximum PREADY-low wait cycles per access phase before the transfer is aborted with an error.

Ports:
- PCLK  input  1  clock.
- PRESET  input  1  asynchronous reset, active-high.
- req_valid  input  NREQ  per-requester request.
- req_data  input  16*NREQ  flattened datawords; requester i uses bits [16i+15:16i].
- req_ready  output  NREQ  one-hot, one-cycle pulse: request i accepted, data captured.
- resp_valid  output  NREQ  one-hot, one-cycle pulse: result for requester i.
- resp_data  output  40  codeword {OUT2[7:0], OUT1[31:0]}; valid while any resp_valid bit is high.
- resp_err  output  1  qualified by resp_valid: slave error or timeout.
- busy  output  1  high in every state except IDLE.
- PADDR  output  32  APB address.
- PWDATA  output  32  APB write data.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PRDATA  input  32  APB read data.
- PREADY  input  1  APB ready.
- PSLVERR  input  1  APB slave error.

Behaviour:
- Reset values (asynchronous, immediate): every output 0; FSM in IDLE; round-robin pointer = 0; latched data, OUT1 and OUT2 registers = 0. A reset mid-transfer drops PSEL/PENABLE at once, and the interrupted request is never answered.
- FSM states: IDLE, WR_SETUP, WR_ACC, R1_SETUP, R1_ACC, R2_SETUP, R2_ACC, RESP.
- IDLE:
  - If any req_valid is high, grant the first asserted requester searching upward from (ptr+1) mod NREQ, wrapping.
  - Pulse req_ready[g], latch req_data[g] and g, set ptr = g, go to WR_SETUP.
  - Requests held in IDLE are arbitrated again every cycle. A requester must hold req_valid until it sees req_ready.
- SETUP states:
  - PSEL=1, PENABLE=0. Next cycle moves to the matching ACC state.
  - WR: PWRITE=1, PADDR=BASE_ADDR+0x0, PWDATA={16'h0, data}.
  - R1: PWRITE=0, PADDR=BASE_ADDR+0x4, PWDATA=0.
  - R2: PWRITE=0, PADDR=BASE_ADDR+0x8, PWDATA=0.
- ACC states:
  - PSEL=1, PENABLE=1; PADDR, PWRITE and PWDATA are held stable.
  - The state is held while PREADY=0; a wait counter counts these cycles.
  - The transfer completes on the edge where PREADY=1.
  - On completion with PSLVERR=0:
    - WR_ACC goes to R1_SETUP;
    - R1_ACC captures OUT1=PRDATA and goes to R2_SETUP;
    - R2_ACC captures OUT2=PRDATA[7:0] and goes to RESP.
  - On completion with PSLVERR=1: set the error flag and go to RESP. Remaining transfers are skipped.
  - Timeout: if the wait counter reaches TIMEOUT while PREADY=0, set the error flag, drop PSEL next cycle and go to RESP.
- Between transfers PSEL goes low for no cycle. Setup follows access directly, so each transfer takes 2 cycles when PREADY=1.
- RESP:
  - Pulse resp_valid[g] for one cycle. resp_data = {OUT2, OUT1}, or 40'h0 when resp_err=1. resp_err = error flag.
  - Clear the error flag and go to IDLE.
- Latency with PREADY=1: from the req_ready pulse to the resp_valid pulse is 7 cycles. The next grant comes no earlier than the cycle after RESP. Throughput is 1 request per 8 cycles.
- Outside SETUP/ACC states, PSEL=PENABLE=PWRITE=0 and PADDR=PWDATA=0.
- req_ready and resp_valid are never high in the same cycle. Only one request is in flight at a time.
- Wait counter: reset at each SETUP, saturates at TIMEOUT.

Test Plan:
- Single request, no wait states. Requester 0 sends 16'hA5C3. Slave model returns OUT1=32'hDEADBEEF and OUT2=32'h0000_00A5.
  -> APB sequence: write @0x0 of 32'h0000A5C3, read @0x4, read @0x8.
  -> req_ready[0] pulses 1 cycle; resp_valid[0] pulses 7 cycles later with resp_data=40'hA5DEADBEEF and resp_err=0.
- Round-robin fairness. Both requesters hold req_valid with data 16'h0001 and 16'h0002 for 4 requests.
  -> Grants alternate 1,0,1,0 (ptr starts at 0, so requester 1 goes first); each resp_valid bit pulses exactly twice.
- Wait states. Slave holds PREADY=0 for 3 cycles in R1_ACC.
  -> PADDR, PWRITE and PENABLE stay stable; latency grows to 10 cycles; result is correct with resp_err=0.
- Slave error. PSLVERR=1 on the write transfer.
  -> No read transfers are issued; resp_err=1 and resp_data=40'h0 on the next cycle.
- Timeout. With TIMEOUT=16, PREADY is held 0 forever in WR_ACC.
  -> After 16 wait cycles PSEL drops, resp_err=1, busy falls one cycle after RESP.
- Asynchronous reset in R2_ACC.
  -> PSEL, PENABLE, busy and all resp/req outputs go to 0 immediately, with no response pulse.
  -> After reset release, a new request completes normally and arbitration starts from ptr=0.
